// File: rtl/periph_instr_arbiter.sv
// periph_instr_arbiter
//   Round-robin arbiter for the module-instruction bus. The peripheral sources are
//   timers 0..2 and the mask block on index 3. The arbiter registers one winner's
//   word and holds it until the CPU FSM accepts it.
//
//   Optional build macro: ARB_BURST_EN. When defined, a req_last input is added.
//   A captured word with req_last=0 locks arbitration onto that requester until it
//   sends a word with req_last=1.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high; clears all state
//   enable     0 blocks new grants; a word already held still drains
//   req        per-requester level request, held until acked
//   req_data   packed words; requester i drives [i*DWORD +: DWORD]
//   req_last   (ARB_BURST_EN only) last-word-of-burst flag per requester
//   req_ack    one-cycle pulse: that requester's word was captured on this edge
//   out_valid  out_data holds a word not yet accepted
//   out_data   granted instruction word
//   out_src    index of the requester that produced out_data
//   out_ready  CPU FSM accepts when out_valid and out_ready are both high
//   busy       same as out_valid
module periph_instr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DWORD   = 16,
    parameter int unsigned SRC_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DWORD-1:0] req_data,
`ifdef ARB_BURST_EN
    input  logic [NUM_REQ-1:0]       req_last,
`endif
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     out_valid,
    output logic [DWORD-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    input  logic                     out_ready,
    output logic                     busy
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e             r_state, w_state_next;
    logic [DWORD-1:0]   r_data, w_data_next;
    logic [SRC_W-1:0]   r_src, w_src_next;
    logic [SRC_W-1:0]   r_last_grant, w_last_next;
    logic [NUM_REQ-1:0] r_ack, w_ack_next;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [SRC_W-1:0]   w_win;
    logic [DWORD-1:0]   w_win_data;
    logic [NUM_REQ-1:0] w_win_onehot;
    int unsigned        w_dist;
    int unsigned        w_best;
    logic               w_free;
    logic               w_capture;

`ifdef ARB_BURST_EN
    logic               r_lock, w_lock_next;
    logic [SRC_W-1:0]   r_lock_src, w_lock_src_next;
    logic               w_win_last;
`endif

    // A requester whose ack is high this cycle has not yet updated its req/word,
    // so it is masked to avoid capturing the same word twice.
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req[i] & ~r_ack[i] & enable;
`ifdef ARB_BURST_EN
            if (r_lock && (r_lock_src != SRC_W'(i))) begin
                w_elig[i] = 1'b0;
            end
`endif
        end
    end

    // Winner is the eligible index nearest after r_last_grant (wrapping), found by
    // ranking each index by its distance from last_grant+1.
    always_comb begin
        w_found      = 1'b0;
        w_win        = '0;
        w_win_data   = '0;
        w_win_onehot = '0;
        w_best       = NUM_REQ;
        w_dist       = 0;
`ifdef ARB_BURST_EN
        w_win_last   = 1'b1;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - 32'(r_last_grant)) % NUM_REQ;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best          = w_dist;
                w_found         = 1'b1;
                w_win           = SRC_W'(i);
                w_win_data      = req_data[i*DWORD +: DWORD];
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
`ifdef ARB_BURST_EN
                w_win_last      = req_last[i];
`endif
            end
        end
    end

    // The output slot is free when nothing is held or the held word leaves now.
    assign w_free    = (r_state == StIdle) || out_ready;
    assign w_capture = w_free && w_found;

    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_src_next      = r_src;
        w_last_next     = r_last_grant;
        w_ack_next      = '0;
`ifdef ARB_BURST_EN
        w_lock_next     = r_lock;
        w_lock_src_next = r_lock_src;
`endif
        if (w_capture) begin
            w_data_next = w_win_data;
            w_src_next  = w_win;
            w_last_next = w_win;
            w_ack_next  = w_win_onehot;
`ifdef ARB_BURST_EN
            w_lock_next     = ~w_win_last;
            w_lock_src_next = w_win;
`endif
        end
        case (r_state)
            StIdle: begin
                if (w_capture) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (out_ready && !w_found) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_data       <= '0;
            r_src        <= '0;
            r_last_grant <= SRC_W'(NUM_REQ - 1);
            r_ack        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_data       <= w_data_next;
            r_src        <= w_src_next;
            r_last_grant <= w_last_next;
            r_ack        <= w_ack_next;
        end
    end

`ifdef ARB_BURST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock     <= 1'b0;
            r_lock_src <= '0;
        end else begin
            r_lock     <= w_lock_next;
            r_lock_src <= w_lock_src_next;
        end
    end
`endif

    assign out_valid = (r_state == StHold);
    assign busy      = out_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign req_ack   = r_ack;

endmodule
